pc_fetch_unit: RTL and testbench

Program-counter stage that drives the PC register bank and presents fetch addresses to instruction memory. It sequences boot, sequential +4 fetch, stall hold and branch redirect, with a valid/ready handshake toward the fetch port. It sits directly upstream of the instruction-memory read and downstream of the branch-resolution logic. It is clocked by the shared clock generator.

---
 rtl/pc_pkg.sv | 17 +
 rtl/pc_reg.sv | 21 ++
 rtl/pc_fetch_unit.sv | 117 +++++++++++
 tb/tb_pc_fetch_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and defaults for the PC fetch stage: address width, instruction size,
// reset/trap vectors and the fetch FSM state encoding.
package pc_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// WIDTH-bit D-register bank with synchronous active-high reset to RESET_VAL and load enable.
module pc_reg #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: boot/fetch/stall sequencing, branch redirect and fetch handshake.
// Optional misaligned-target trap is enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int unsigned      XLEN         = pc_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(pc_pkg::RESET_VECTOR)
`ifdef PC_MISALIGN_TRAP_EN
  , parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(pc_pkg::TRAP_VECTOR)
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            flush,
  output logic [31:0]     fetch_count,
  output logic            misaligned,
  output logic [XLEN-1:0] bad_addr
);

  localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);

  fetch_state_e    state_q, state_d;
  logic            accept;
  logic            redirect;
  logic            pc_load;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] redirect_pc;

  assign accept   = pc_valid & fetch_ready & ~stall;
  // Redirects arriving during the boot cycle are dropped.
  assign redirect = branch_taken & (state_q != BOOT);

`ifdef PC_MISALIGN_TRAP_EN
  logic target_mis;
  assign target_mis  = |branch_target[1:0];
  assign redirect_pc = target_mis ? TRAP_VECTOR : (branch_target & ALIGN_MASK);

  always_ff @(posedge clk) begin
    if (reset) begin
      misaligned <= 1'b0;
      bad_addr   <= '0;
    end else begin
      misaligned <= redirect & target_mis;
      if (redirect && target_mis) begin
        bad_addr <= branch_target;
      end
    end
  end
`else
  assign redirect_pc = branch_target & ALIGN_MASK;
  assign misaligned  = 1'b0;
  assign bad_addr    = '0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc + STEP;
    pc_load = 1'b0;
    case (state_q)
      BOOT:  state_d = stall ? STALL : FETCH;
      FETCH: begin
        if (stall) begin
          state_d = STALL;
        end else if (accept) begin
          pc_load = 1'b1;
        end
      end
      STALL: begin
        if (!stall) begin
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
    // Redirect overrides the sequential pc; the accept still counts below.
    if (redirect) begin
      pc_d    = redirect_pc;
      pc_load = 1'b1;
      state_d = stall ? STALL : FETCH;
    end
  end

  pc_reg #(
    .WIDTH     (XLEN),
    .RESET_VAL (RESET_VECTOR)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .load  (pc_load),
    .d     (pc_d),
    .q     (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= BOOT;
      pc_valid    <= 1'b0;
      flush       <= 1'b0;
      fetch_count <= '0;
    end else begin
      state_q  <= state_d;
      pc_valid <= (state_d == FETCH);
      flush    <= redirect;
      if (accept) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed vector bench for pc_fetch_unit; expected misaligned-trap results follow PC_MISALIGN_TRAP_EN.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        fetch_ready;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic [31:0] fetch_count;
  logic        misaligned;
  logic [31:0] bad_addr;

  int unsigned checks = 0;
  int unsigned errors = 0;

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [31:0] MIS_PC  = 32'h0000_0100;
  localparam logic        MIS_F   = 1'b1;
  localparam logic [31:0] MIS_BAD = 32'h0000_0202;
`else
  localparam logic [31:0] MIS_PC  = 32'h0000_0200;
  localparam logic        MIS_F   = 1'b0;
  localparam logic [31:0] MIS_BAD = 32'h0000_0000;
`endif

  pc_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .fetch_ready   (fetch_ready),
    .pc            (pc),
    .pc_valid      (pc_valid),
    .flush         (flush),
    .fetch_count   (fetch_count),
    .misaligned    (misaligned),
    .bad_addr      (bad_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic [31:0] e_pc;
    logic        e_valid;
    logic        e_flush;
    logic [31:0] e_cnt;
    logic        e_mis;
    logic [31:0] e_bad;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(input logic rst, stl, br, input logic [31:0] tgt, input logic rdy,
                             input logic [31:0] e_pc, input logic e_valid, e_flush,
                             input logic [31:0] e_cnt, input logic e_mis, input logic [31:0] e_bad);
    vec_t r;
    r.rst = rst; r.stl = stl; r.br = br; r.tgt = tgt; r.rdy = rdy;
    r.e_pc = e_pc; r.e_valid = e_valid; r.e_flush = e_flush;
    r.e_cnt = e_cnt; r.e_mis = e_mis; r.e_bad = e_bad;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, stl, br, input logic [31:0] tgt, input logic rdy);
    reset = rst; stall = stl; branch_taken = br; branch_target = tgt; fetch_ready = rdy;
  endtask

  logic [19:0] rdy_pat;
  logic [31:0] m_pc, m_cnt;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    //        rst stl br tgt           rdy  pc            vld fl cnt    mis    bad
    vq.push_back(v(1, 0, 0, 32'h0,        0, 32'h0000_0000, 0, 0, 32'd0,  0,     32'h0));   // 0 reset
    vq.push_back(v(0, 0, 0, 32'h0,        1, 32'h0000_0000, 1, 0, 32'd0,  0,     32'h0));   // 1 boot->fetch
    vq.push_back(v(0, 0, 0, 32'h0,        1, 32'h0000_0004, 1, 0, 32'd1,  0,     32'h0));
    vq.push_back(v(0, 0, 0, 32'h0,        1, 32'h0000_0008, 1, 0, 32'd2,  0,     32'h0));
    vq.push_back(v(0, 0, 0, 32'h0,        0, 32'h0000_0008, 1, 0, 32'd2,  0,     32'h0));   // 4 not ready x3
    vq.push_back(v(0, 0, 0, 32'h0,        0, 32'h0000_0008, 1, 0, 32'd2,  0,     32'h0));
    vq.push_back(v(0, 0, 0, 32'h0,        0, 32'h0000_0008, 1, 0, 32'd2,  0,     32'h0));
    vq.push_back(v(0, 0, 0, 32'h0,        1, 32'h0000_000C, 1, 0, 32'd3,  0,     32'h0));
    vq.push_back(v(0, 0, 0, 32'h0,        1, 32'h0000_0010, 1, 0, 32'd4,  0,     32'h0));
    vq.push_back(v(0, 1, 0, 32'h0,        1, 32'h0000_0010, 0, 0, 32'd4,  0,     32'h0));   // 9 stall x2
    vq.push_back(v(0, 1, 0, 32'h0,        1, 32'h0000_0010, 0, 0, 32'd4,  0,     32'h0));
    vq.push_back(v(0, 0, 0, 32'h0,        0, 32'h0000_0010, 1, 0, 32'd4,  0,     32'h0));   // 11 resume
    vq.push_back(v(0, 0, 0, 32'h0,        1, 32'h0000_0014, 1, 0, 32'd5,  0,     32'h0));
    vq.push_back(v(0, 0, 0, 32'h0,        1, 32'h0000_0018, 1, 0, 32'd6,  0,     32'h0));
    vq.push_back(v(0, 0, 0, 32'h0,        1, 32'h0000_001C, 1, 0, 32'd7,  0,     32'h0));
    vq.push_back(v(0, 0, 0, 32'h0,        1, 32'h0000_0020, 1, 0, 32'd8,  0,     32'h0));
    vq.push_back(v(0, 0, 1, 32'h200,      1, 32'h0000_0200, 1, 1, 32'd9,  0,     32'h0));   // 16 redirect+accept
    vq.push_back(v(0, 0, 0, 32'h0,        0, 32'h0000_0200, 1, 0, 32'd9,  0,     32'h0));
    vq.push_back(v(0, 1, 0, 32'h0,        0, 32'h0000_0200, 0, 0, 32'd9,  0,     32'h0));
    vq.push_back(v(0, 1, 1, 32'h240,      1, 32'h0000_0240, 0, 1, 32'd9,  0,     32'h0));   // 19 redirect in STALL
    vq.push_back(v(0, 1, 0, 32'h0,        1, 32'h0000_0240, 0, 0, 32'd9,  0,     32'h0));
    vq.push_back(v(0, 0, 0, 32'h0,        0, 32'h0000_0240, 1, 0, 32'd9,  0,     32'h0));
    vq.push_back(v(0, 0, 1, 32'hFFFF_FFFC,0, 32'hFFFF_FFFC, 1, 1, 32'd9,  0,     32'h0));   // 22 wrap setup
    vq.push_back(v(0, 0, 0, 32'h0,        1, 32'h0000_0000, 1, 0, 32'd10, 0,     32'h0));
    vq.push_back(v(0, 0, 1, 32'h202,      1, MIS_PC,        1, 1, 32'd11, MIS_F, MIS_BAD)); // 24 misaligned
    vq.push_back(v(0, 0, 0, 32'h0,        0, MIS_PC,        1, 0, 32'd11, 0,     MIS_BAD));
    vq.push_back(v(1, 0, 1, 32'h400,      1, 32'h0000_0000, 0, 0, 32'd0,  0,     32'h0));   // 26 reset beats redirect
    vq.push_back(v(0, 0, 1, 32'h500,      1, 32'h0000_0000, 1, 0, 32'd0,  0,     32'h0));   // 27 boot ignores branch
    vq.push_back(v(0, 0, 0, 32'h0,        1, 32'h0000_0004, 1, 0, 32'd1,  0,     32'h0));
    vq.push_back(v(1, 0, 0, 32'h0,        1, 32'h0000_0000, 0, 0, 32'd0,  0,     32'h0));
    vq.push_back(v(0, 1, 0, 32'h0,        1, 32'h0000_0000, 0, 0, 32'd0,  0,     32'h0));   // 30 boot->stall
    vq.push_back(v(0, 0, 0, 32'h0,        1, 32'h0000_0000, 1, 0, 32'd0,  0,     32'h0));

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].stl, vq[i].br, vq[i].tgt, vq[i].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d pc", i),         pc,                  vq[i].e_pc);
      chk($sformatf("v%0d pc_valid", i),   {31'd0, pc_valid},   {31'd0, vq[i].e_valid});
      chk($sformatf("v%0d flush", i),      {31'd0, flush},      {31'd0, vq[i].e_flush});
      chk($sformatf("v%0d fetch_count", i), fetch_count,        vq[i].e_cnt);
      chk($sformatf("v%0d misaligned", i), {31'd0, misaligned}, {31'd0, vq[i].e_mis});
      chk($sformatf("v%0d bad_addr", i),   bad_addr,            vq[i].e_bad);
    end

    // Ready toggling against a small pc/count model; DUT is in FETCH at pc=0 here.
    rdy_pat = 20'b1011_0011_1010_0111_0001;
    m_pc  = 32'h0;
    m_cnt = 32'd0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, rdy_pat[i]);
      @(posedge clk);
      #1;
      if (rdy_pat[i]) begin
        m_pc  = m_pc + 32'd4;
        m_cnt = m_cnt + 32'd1;
      end
      chk($sformatf("hs%0d pc", i),          pc,                m_pc);
      chk($sformatf("hs%0d fetch_count", i), fetch_count,       m_cnt);
      chk($sformatf("hs%0d pc_valid", i),    {31'd0, pc_valid}, 32'd1);
    end

    // Single-cycle stall: valid drops for one cycle, pc holds, nothing counted.
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    chk("st pc", pc, m_pc);
    chk("st pc_valid", {31'd0, pc_valid}, 32'd0);
    chk("st fetch_count", fetch_count, m_cnt);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    chk("st resume pc", pc, m_pc);
    chk("st resume pc_valid", {31'd0, pc_valid}, 32'd1);
    @(posedge clk);
    #1;
    chk("st accept pc", pc, m_pc + 32'd4);
    chk("st accept fetch_count", fetch_count, m_cnt + 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
